fifo_read_streamer: RTL

//  Read-side consumer for the dual-clock 8-bit FIFO. It sits in the read_clk domain,

---
 rtl/fifo_read_streamer.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_read_streamer.sv
// Read-side consumer for the dual-clock byte FIFO: pops bytes, buffers them in a
// 2-entry skid buffer and re-presents them as a valid/ready stream framed into packets.
module fifo_read_streamer #(
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             read_clk,
    input  logic             reset,
    input  logic             stream_enable,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_read_data,
    output logic             fifo_read_enable,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count
);
    localparam int unsigned      IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       buf_q   [2];
    logic [7:0]       buf_nxt [2];
    logic             head;
    logic             head_nxt;
    logic             inflight;
    logic             fire;
    logic             pop_ok;
    logic [1:0]       occ;
    logic [1:0]       occ_nxt;
    logic [IDX_W-1:0] pop_idx;
    logic [IDX_W-1:0] pop_idx_nxt;
    logic [IDX_W-1:0] beat_idx;
    logic [IDX_W-1:0] beat_idx_nxt;

    // Pop decision and next-state of buffer, packet counters and FSM.
    // occ_nxt already accounts for this cycle's landing byte and fire, so the
    // pop rule can never overfill the 2-entry buffer.
    always_comb begin
        fire             = out_valid & out_ready;
        pop_ok           = (state == RUN) || ((state == FINISH) && (pop_idx != '0));
        occ_nxt          = occ + 2'(inflight) - 2'(fire);
        fifo_read_enable = pop_ok && !fifo_empty && (occ_nxt < 2'd2);
        head_nxt         = head ^ fire;

        buf_nxt = buf_q;
        if (inflight) begin
            buf_nxt[head ^ occ[0]] = fifo_read_data;
        end

        pop_idx_nxt = pop_idx;
        if (fifo_read_enable) begin
            pop_idx_nxt = (pop_idx == IDX_LAST) ? '0 : pop_idx + IDX_W'(1);
        end

        beat_idx_nxt = beat_idx;
        if (fire) begin
            beat_idx_nxt = (beat_idx == IDX_LAST) ? '0 : beat_idx + IDX_W'(1);
        end

        state_nxt = state;
        case (state)
            IDLE:    if (stream_enable) state_nxt = RUN;
            RUN:     if (!stream_enable) state_nxt = (pop_idx_nxt == '0) ? IDLE : FINISH;
            FINISH:  if (pop_idx_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge read_clk) begin
        if (reset) begin
            state      <= IDLE;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            head       <= 1'b0;
            occ        <= '0;
            inflight   <= 1'b0;
            pop_idx    <= '0;
            beat_idx   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            byte_count <= '0;
        end else begin
            state      <= state_nxt;
            buf_q      <= buf_nxt;
            head       <= head_nxt;
            occ        <= occ_nxt;
            inflight   <= fifo_read_enable;
            pop_idx    <= pop_idx_nxt;
            beat_idx   <= beat_idx_nxt;
            out_valid  <= (occ_nxt != '0);
            out_data   <= buf_nxt[head_nxt];
            out_last   <= (occ_nxt != '0) && (beat_idx_nxt == IDX_LAST);
            busy       <= (state_nxt != IDLE) || (occ_nxt != '0) || fifo_read_enable;
            byte_count <= byte_count + CNT_W'(fire);
        end
    end

    // A landing byte must always find a free slot.
    always_ff @(posedge read_clk) begin
        if (!reset) begin
            assert (!(inflight && occ[1]) && (occ != 2'd3));
        end
    end

endmodule
